// File: rtl/subtrator_serial_if.sv
// Handshake and data bundle for the bit-serial subtractor.
// The requester drives start/a/b; the subtractor answers with busy/done/d/bout.
interface subtrator_serial_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] d;
  logic         bout;

  modport master (
    output start, a, b,
    input  busy, done, d, bout
  );

  modport slave (
    input  start, a, b,
    output busy, done, d, bout
  );
endinterface

// File: rtl/subtrator_serial.sv
// Bit-serial N-bit subtractor: d = a - b, LSB first, one full-subtractor
// step per clock with a single borrow flip-flop. A start pulse loads the
// operands; done pulses for one cycle once d and the final borrow are valid.
module subtrator_serial #(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  subtrator_serial_if.slave     bus
);

  localparam int CW = (N > 1) ? $clog2(N + 1) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;
  logic          accept;
  logic          last_bit;

  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic          borrow;
  logic [CW-1:0] count;
  logic [N-1:0]  d_q;
  logic          bout_q;
  logic          busy_q;
  logic          done_q;

  logic          di;
  logic          bnew;
  logic [N-1:0]  d_next;

  // One full-subtractor step on the current operand LSBs and stored borrow.
  assign di       = a_sr[0] ^ b_sr[0] ^ borrow;
  assign bnew     = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
  // New difference bit enters from the MSB side so that after N steps
  // bit 0 of the result has travelled down to d[0].
  assign d_next   = (d_q >> 1) | (N'(di) << (N - 1));
  assign last_bit = (count == LAST_BIT);

  // Next-state logic: start is honoured only in IDLE or DONE.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    next_state = state;
    accept     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (last_bit) next_state = S_DONE;
      end
      S_DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          next_state = S_SHIFT;
        end else begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // State register with registered busy/done flags derived from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= next_state;
      busy_q <= (next_state == S_SHIFT);
      done_q <= (next_state == S_DONE);
    end
  end

  // Datapath: load operands on accept, otherwise shift one bit per SHIFT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the shift registers are ordinary flops, not a memory array, so
    // they are all cleared by reset and an aborted operation leaves no trace.
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      borrow <= 1'b0;
      count  <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
    end else if (accept) begin
      a_sr   <= bus.a;
      b_sr   <= bus.b;
      borrow <= 1'b0;
      count  <= '0;
    end else if (state == S_SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      borrow <= bnew;
      count  <= count + CW'(1);
      d_q    <= d_next;
      if (last_bit) bout_q <= bnew;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.d    = d_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_subtrator_serial.sv
// Self-checking bench for subtrator_serial (N=4): directed corner cases plus
// random operands, compared against plain unsigned arithmetic.
module tb_subtrator_serial;

  localparam int N = 4;

  logic clk;
  logic rst_n;

  subtrator_serial_if #(.N(N)) bus ();

  subtrator_serial #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Reference: unsigned subtraction modulo 2^N, borrow iff a < b.
  function automatic logic [N-1:0] ref_d(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N:0] full;
    full = {1'b0, x} - {1'b0, y};
    return full[N-1:0];
  endfunction

  function automatic logic ref_b(input logic [N-1:0] x, input logic [N-1:0] y);
    return (x < y);
  endfunction

  // One complete operation from start to done, optionally pulsing start
  // mid-operation with different operands that must be ignored.
  task automatic do_op(input logic [N-1:0] x, input logic [N-1:0] y, input bit pulse,
                       input string tag);
    int cycles;
    int busy_cnt;
    logic [N-1:0] ed;
    logic eb;
    ed = ref_d(x, y);
    eb = ref_b(x, y);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = x;
    bus.b     = y;
    cycles    = 0;
    busy_cnt  = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (pulse && cycles == 2) begin
        bus.start = 1'b1;
        bus.a     = 4'd1;
        bus.b     = 4'd2;
      end else begin
        bus.start = 1'b0;
        if (cycles == 1) begin
          bus.a = N'($urandom);
          bus.b = N'($urandom);
        end
      end
      if (bus.busy) busy_cnt++;
    end while (!bus.done && cycles < 64);
    check({tag, " done seen"}, 32'(bus.done), 32'd1);
    check({tag, " latency"}, 32'(cycles), 32'(N + 1));
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'(N));
    check({tag, " d"}, 32'(bus.d), 32'(ed));
    check({tag, " bout"}, 32'(bus.bout), 32'(eb));
    @(negedge clk);
    check({tag, " done single"}, 32'(bus.done), 32'd0);
    check({tag, " d held"}, 32'(bus.d), 32'(ed));
    check({tag, " idle not busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_done(output int cycles, input bit drop_start);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (drop_start && cycles == 1) bus.start = 1'b0;
    end while (!bus.done && cycles < 64);
    check("wait done seen", 32'(bus.done), 32'd1);
  endtask

  initial begin
    int cyc;
    logic [N-1:0] rx;
    logic [N-1:0] ry;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #1;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset d", 32'(bus.d), 32'd0);
    check("reset bout", 32'(bus.bout), 32'd0);
    #11 rst_n = 1'b1;

    // Directed cases.
    do_op(4'd7,  4'd3,  1'b0, "7-3");
    do_op(4'd3,  4'd7,  1'b0, "3-7");
    do_op(4'd0,  4'd1,  1'b0, "0-1");
    do_op(4'd0,  4'd0,  1'b0, "0-0");
    do_op(4'd15, 4'd15, 1'b0, "15-15");
    do_op(4'd15, 4'd0,  1'b0, "15-0");
    do_op(4'd9,  4'd4,  1'b1, "9-4 ignore");

    // Reset in the middle of an operation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 4'd9;
    bus.b     = 4'd2;
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset busy", 32'(bus.busy), 32'd0);
    check("midreset done", 32'(bus.done), 32'd0);
    check("midreset d", 32'(bus.d), 32'd0);
    check("midreset bout", 32'(bus.bout), 32'd0);
    @(negedge clk);
    check("midreset held idle", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    do_op(4'd6, 4'd6, 1'b0, "6-6 after reset");

    // Back-to-back: start held through the done cycle.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 4'd10;
    bus.b     = 4'd3;
    wait_done(cyc, 1'b0);
    check("b2b first latency", 32'(cyc), 32'(N + 1));
    check("b2b first d", 32'(bus.d), 32'd7);
    check("b2b first bout", 32'(bus.bout), 32'd0);
    bus.a = 4'd2;
    bus.b = 4'd5;
    wait_done(cyc, 1'b1);
    check("b2b spacing", 32'(cyc), 32'(N + 1));
    check("b2b second d", 32'(bus.d), 32'd13);
    check("b2b second bout", 32'(bus.bout), 32'd1);
    @(negedge clk);
    check("b2b done single", 32'(bus.done), 32'd0);

    // Random operands, some with an ignored mid-operation start pulse.
    for (int i = 0; i < 24; i++) begin
      rx = N'($urandom);
      ry = N'($urandom);
      do_op(rx, ry, bit'($urandom_range(0, 1)), $sformatf("rand%0d %0d-%0d", i, rx, ry));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
